// File: rtl/bit_plane_packer_if.sv
// Pixel-in / plane-byte-out stream bundle for bit_plane_packer.
//   pixel, pix_valid, pix_ready      : 8-bit pixel stream from the image reader
//   out_data, out_plane, out_valid,
//   out_ready, out_last              : packed plane byte stream to the encoders
// slave  = packer side, master = the producer/consumer side driving it.
interface bit_plane_packer_if;
  logic [7:0] pixel;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] out_data;
  logic [2:0] out_plane;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport slave (
    input  pixel, pix_valid, out_ready,
    output pix_ready, out_data, out_plane, out_valid, out_last
  );
  modport master (
    output pixel, pix_valid, out_ready,
    input  pix_ready, out_data, out_plane, out_valid, out_last
  );
endinterface

// File: rtl/bit_plane_packer.sv
// bit_plane_packer: splits each 8-bit pixel into its 8 bit planes, packs 8
// consecutive pixels per plane into one byte and emits the 8 plane bytes
// (plane 0 = LSB plane first) over a valid/ready handshake. One frame of
// NUM_PIXELS pixels is processed per start pulse.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle frame start, honoured only in IDLE
//   s          : stream bundle (slave side), see bit_plane_packer_if
//   busy       : high in every state but IDLE
//   done       : one-cycle pulse when a frame has been fully emitted
// Optional: define BIT_PLANE_GRAY_EN to Gray-code each pixel before splitting.
module bit_plane_packer #(
  parameter int NUM_PIXELS = 65536,
  parameter int PIX_CNT_W  = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  bit_plane_packer_if.slave  s,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DONE} state_t;

  state_t                 state;
  logic [7:0][7:0]        plane;
  logic [7:0][7:0]        plane_nxt;
  logic [3:0]             grp_cnt;   // {full, count[2:0]}
  logic [3:0]             grp_nxt;
  logic [PIX_CNT_W-1:0]   pix_cnt;
  logic [2:0]             idx;
  logic [2:0]             idx_nxt;
  logic                   last_grp;  // current group is the frame's final one
  logic [7:0]             px;
  logic                   accept;
  logic                   frame_end;
  logic                   grp_end;

`ifdef BIT_PLANE_GRAY_EN
  assign px = s.pixel ^ (s.pixel >> 1);
`else
  assign px = s.pixel;
`endif

  assign accept    = (state == COLLECT) && s.pix_valid && s.pix_ready;
  assign grp_nxt   = grp_cnt + 4'd1;
  assign grp_end   = grp_nxt[3];
  assign frame_end = (pix_cnt == PIX_CNT_W'(NUM_PIXELS - 1));
  assign idx_nxt   = idx + 3'd1;

  // Shift the accepted pixel's bits into every plane. A short final group is
  // pushed up so the first pixel still lands in bit 7 and the unused LSBs are 0.
  always_comb begin
    plane_nxt = plane;
    for (int k = 0; k < 8; k++) begin
      plane_nxt[k] = {plane[k][6:0], px[k]};
      if (frame_end && !grp_end)
        plane_nxt[k] = plane_nxt[k] << (4'd8 - grp_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      plane       <= '0;
      grp_cnt     <= '0;
      pix_cnt     <= '0;
      idx         <= '0;
      last_grp    <= 1'b0;
      s.pix_ready <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_plane <= '0;
      s.out_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= COLLECT;
            pix_cnt     <= '0;
            grp_cnt     <= '0;
            idx         <= '0;
            last_grp    <= 1'b0;
            plane       <= '0;
            s.pix_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept) begin
            plane   <= plane_nxt;
            pix_cnt <= pix_cnt + 1'b1;
            grp_cnt <= grp_nxt;
            if (grp_end || frame_end) begin
              // Plane 0 goes out the cycle after the group-completing pixel.
              state       <= EMIT;
              s.pix_ready <= 1'b0;
              s.out_valid <= 1'b1;
              s.out_data  <= plane_nxt[0];
              s.out_plane <= 3'd0;
              s.out_last  <= 1'b0;
              last_grp    <= frame_end;
              idx         <= 3'd0;
            end
          end
        end
        EMIT: begin
          if (s.out_ready) begin
            if (idx == 3'd7) begin
              s.out_valid <= 1'b0;
              s.out_data  <= '0;
              s.out_plane <= '0;
              s.out_last  <= 1'b0;
              idx         <= '0;
              if (last_grp) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state       <= COLLECT;
                grp_cnt     <= '0;
                s.pix_ready <= 1'b1;
              end
            end else begin
              idx         <= idx_nxt;
              s.out_data  <= plane[idx_nxt];
              s.out_plane <= idx_nxt;
              s.out_last  <= last_grp && (idx_nxt == 3'd7);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_plane_packer.sv
// Self-checking bench for bit_plane_packer. Two instances share the input
// drive: u8 (NUM_PIXELS=8) and u10 (NUM_PIXELS=10); sel10 picks whose outputs
// the stream driver observes. Expected plane bytes come from a bit-placement
// model pushed into a scoreboard queue before each frame is driven.
module tb_bit_plane_packer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start10;
  logic [7:0] pixel;
  logic       pix_valid, out_ready;
  logic       busy8, done8, busy10, done10;
  logic       sel10;

  always #5 clk = ~clk;

  bit_plane_packer_if if8();
  bit_plane_packer_if if10();

  assign if8.pixel      = pixel;
  assign if8.pix_valid  = pix_valid;
  assign if8.out_ready  = out_ready;
  assign if10.pixel     = pixel;
  assign if10.pix_valid = pix_valid;
  assign if10.out_ready = out_ready;

  bit_plane_packer #(.NUM_PIXELS(8), .PIX_CNT_W(4)) u8 (
    .clk(clk), .rst(rst), .start(start8), .s(if8), .busy(busy8), .done(done8));
  bit_plane_packer #(.NUM_PIXELS(10), .PIX_CNT_W(4)) u10 (
    .clk(clk), .rst(rst), .start(start10), .s(if10), .busy(busy10), .done(done10));

  logic       o_valid, o_last, o_pix_ready, o_done;
  logic [7:0] o_data;
  logic [2:0] o_plane;
  assign o_valid     = sel10 ? if10.out_valid : if8.out_valid;
  assign o_last      = sel10 ? if10.out_last  : if8.out_last;
  assign o_data      = sel10 ? if10.out_data  : if8.out_data;
  assign o_plane     = sel10 ? if10.out_plane : if8.out_plane;
  assign o_pix_ready = sel10 ? if10.pix_ready : if8.pix_ready;
  assign o_done      = sel10 ? done10         : done8;

  int total = 0;
  int bad   = 0;

  logic [7:0]  pix_q[$];
  logic [11:0] sb[$];   // {last, plane, data}
  logic [11:0] rx[$];
  int t_grp_acc, t_first_valid, t_last_acc, t_done, done_cnt;
  int hold_err, pr_err, timeout, aborted;

  function automatic logic [7:0] enc(input logic [7:0] p);
`ifdef BIT_PLANE_GRAY_EN
    return p ^ (p >> 1);
`else
    return p;
`endif
  endfunction

  // Pixel j of a group owns bit 7-j of each plane byte.
  task automatic push_expect();
    int n;
    n = pix_q.size();
    for (int g = 0; g * 8 < n; g++) begin
      int m;
      logic [7:0] b, v;
      logic lst;
      m = (n - 8 * g) < 8 ? (n - 8 * g) : 8;
      for (int k = 0; k < 8; k++) begin
        b = 8'h00;
        for (int j = 0; j < m; j++) begin
          v = enc(pix_q[8 * g + j]);
          b[7 - j] = v[k];
        end
        lst = (8 * g + 8 >= n) && (k == 7);
        sb.push_back({lst, 3'(k), b});
      end
    end
  endtask

  task automatic rand_pixels(input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Drives one frame: start pulse, pixels while pix_ready, accepts bytes.
  // Optional stall on one plane (and a start poke during the stall) and an
  // early exit when a given plane is first presented.
  task automatic run_frame(input bit s10, input int stall_plane, input int stall_cyc,
                           input bit poke_start, input int abort_plane);
    int sent, stall_left, it;
    bit stalled_prev;
    logic [11:0] held, cur;
    sent = 0; stall_left = stall_cyc; stalled_prev = 0; held = '0;
    rx.delete();
    t_grp_acc = -1; t_first_valid = -1; t_last_acc = -1; t_done = -1;
    done_cnt = 0; hold_err = 0; pr_err = 0; timeout = 0; aborted = 0;
    sel10 = s10;
    @(negedge clk);
    if (s10) start10 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; start10 = 1'b0;
    it = 1;
    while (1) begin
      cur = {o_last, o_plane, o_data};
      if (o_done) begin
        done_cnt++;
        if (t_done < 0) t_done = it;
      end
      if (o_valid && t_first_valid < 0) t_first_valid = it;
      if (stalled_prev) begin
        if (!o_valid || cur !== held) hold_err++;
        if (o_pix_ready) pr_err++;
      end
      if (abort_plane >= 0 && o_valid && o_plane == abort_plane[2:0]) begin
        aborted = 1;
        break;
      end
      if (sent < pix_q.size()) begin
        pixel = pix_q[sent];
        pix_valid = 1'b1;
        if (o_pix_ready) begin
          sent++;
          if (sent % 8 == 0 && t_grp_acc < 0) t_grp_acc = it;
        end
      end else begin
        pix_valid = 1'b0;
      end
      out_ready = 1'b1;
      stalled_prev = 0;
      if (o_valid) begin
        if (stall_plane >= 0 && o_plane == stall_plane[2:0] && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          stalled_prev = 1;
          held = cur;
        end else begin
          rx.push_back(cur);
          if (o_last) t_last_acc = it;
        end
      end
      if (s10) start10 = poke_start && stalled_prev;
      else     start8  = poke_start && stalled_prev;
      if (t_done >= 0 && it >= t_done + 2) break;
      if (it > 400) begin
        timeout = 1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      it++;
    end
    pix_valid = 1'b0;
    out_ready = 1'b1;
    start8 = 1'b0;
    start10 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({if8.pix_ready, if8.out_valid, if8.out_data, if8.out_plane, if8.out_last, busy8, done8} !== 15'd0) begin
      bad++;
      $display("FAIL reset_u8 got=%h want=0", {if8.pix_ready, if8.out_valid, if8.out_data, if8.out_plane, if8.out_last, busy8, done8});
    end
    total++;
    if ({if10.pix_ready, if10.out_valid, if10.out_data, if10.out_plane, if10.out_last, busy10, done10} !== 15'd0) begin
      bad++;
      $display("FAIL reset_u10 got=%h want=0", {if10.pix_ready, if10.out_valid, if10.out_data, if10.out_plane, if10.out_last, busy10, done10});
    end
    @(negedge clk);
    rst = 1'b0;
    // Pixels offered while idle must not be taken.
    pix_valid = 1'b1;
    pixel = 8'h5A;
    repeat (3) @(negedge clk);
    total++;
    if ({if8.pix_ready, busy8, if8.out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL idle_ignore got=%b want=000", {if8.pix_ready, busy8, if8.out_valid});
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_single_group();
    logic [11:0] e, g;
    pix_q.delete();
    repeat (8) pix_q.push_back(8'hFF);
    push_expect();
    run_frame(1'b0, -1, 0, 1'b0, -1);
    total++;
    if (timeout !== 0) begin bad++; $display("FAIL single_timeout got=%0d want=0", timeout); end
    total++;
    if (rx.size() !== sb.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", rx.size(), sb.size()); end
    while (sb.size() > 0 && rx.size() > 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL single_byte got=%h want=%h", g, e); end
    end
    total++;
    if (t_done !== t_last_acc + 1) begin bad++; $display("FAIL single_done_time got=%0d want=%0d", t_done, t_last_acc + 1); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL single_done_cnt got=%0d want=1", done_cnt); end
    sb.delete();
  endtask

  task automatic test_pattern();
    logic [11:0] e, g;
    pix_q.delete();
    pix_q.push_back(8'h01);
    repeat (6) pix_q.push_back(8'h00);
    pix_q.push_back(8'h80);
    push_expect();
    run_frame(1'b0, -1, 0, 1'b0, -1);
    total++;
    if (t_first_valid !== t_grp_acc + 1) begin bad++; $display("FAIL latency got=%0d want=%0d", t_first_valid, t_grp_acc + 1); end
    total++;
    if (rx.size() != 8 || rx[0][7:0] !== 8'h80) begin bad++; $display("FAIL pattern_plane0 got=%h want=80", rx.size() > 0 ? rx[0][7:0] : 8'hxx); end
    total++;
    if (rx.size() !== sb.size()) begin bad++; $display("FAIL pattern_count got=%0d want=%0d", rx.size(), sb.size()); end
    while (sb.size() > 0 && rx.size() > 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL pattern_byte got=%h want=%h", g, e); end
    end
    sb.delete();
  endtask

  task automatic test_partial_group();
    logic [11:0] e, g;
    pix_q.delete();
    repeat (10) pix_q.push_back(8'hAA);
    push_expect();
    run_frame(1'b1, -1, 0, 1'b0, -1);
    total++;
    if (rx.size() !== 16) begin bad++; $display("FAIL partial_count got=%0d want=16", rx.size()); end
    while (sb.size() > 0 && rx.size() > 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL partial_byte got=%h want=%h", g, e); end
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL partial_done_cnt got=%0d want=1", done_cnt); end
    sb.delete();
  endtask

  task automatic test_backpressure();
    logic [11:0] e, g;
    rand_pixels(8);
    push_expect();
    run_frame(1'b0, 3, 5, 1'b1, -1);
    total++;
    if (hold_err !== 0) begin bad++; $display("FAIL bp_hold got=%0d want=0", hold_err); end
    total++;
    if (pr_err !== 0) begin bad++; $display("FAIL bp_pix_ready got=%0d want=0", pr_err); end
    total++;
    if (rx.size() !== sb.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", rx.size(), sb.size()); end
    while (sb.size() > 0 && rx.size() > 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL bp_byte got=%h want=%h", g, e); end
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL bp_done_cnt got=%0d want=1", done_cnt); end
    sb.delete();
  endtask

  task automatic test_abort();
    logic [11:0] e, g;
    int dseen;
    rand_pixels(8);
    run_frame(1'b0, -1, 0, 1'b0, 4);
    total++;
    if (aborted !== 1) begin bad++; $display("FAIL abort_reach got=%0d want=1", aborted); end
    rst = 1'b1;
    #1;
    total++;
    if ({if8.pix_ready, if8.out_valid, if8.out_data, if8.out_plane, if8.out_last, busy8, done8} !== 15'd0) begin
      bad++;
      $display("FAIL abort_outputs got=%h want=0", {if8.pix_ready, if8.out_valid, if8.out_data, if8.out_plane, if8.out_last, busy8, done8});
    end
    @(negedge clk);
    rst = 1'b0;
    dseen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done8) dseen++;
    end
    total++;
    if (dseen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dseen); end
    rand_pixels(8);
    push_expect();
    run_frame(1'b0, -1, 0, 1'b0, -1);
    total++;
    if (rx.size() !== sb.size()) begin bad++; $display("FAIL abort_count got=%0d want=%0d", rx.size(), sb.size()); end
    while (sb.size() > 0 && rx.size() > 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL abort_byte got=%h want=%h", g, e); end
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL abort_done_cnt got=%0d want=1", done_cnt); end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [11:0] e, g;
    for (int f = 0; f < 2; f++) begin
      rand_pixels(10);
      push_expect();
      run_frame(1'b1, (f == 0) ? 7 : 0, 2, 1'b0, -1);
      total++;
      if (rx.size() !== sb.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", rx.size(), sb.size()); end
      while (sb.size() > 0 && rx.size() > 0) begin
        e = sb.pop_front(); g = rx.pop_front(); total++;
        if (g !== e) begin bad++; $display("FAIL b2b_byte got=%h want=%h", g, e); end
      end
      sb.delete();
    end
  endtask

  task automatic test_gray();
    logic [11:0] e, g;
    logic [7:0] want6;
`ifdef BIT_PLANE_GRAY_EN
    want6 = 8'hFF;
`else
    want6 = 8'h00;
`endif
    pix_q.delete();
    repeat (8) pix_q.push_back(8'h80);
    push_expect();
    run_frame(1'b0, -1, 0, 1'b0, -1);
    total++;
    if (rx.size() != 8 || rx[6][7:0] !== want6) begin bad++; $display("FAIL gray_plane6 got=%h want=%h", rx.size() > 6 ? rx[6][7:0] : 8'hxx, want6); end
    total++;
    if (rx.size() != 8 || rx[7][7:0] !== 8'hFF) begin bad++; $display("FAIL gray_plane7 got=%h want=ff", rx.size() > 7 ? rx[7][7:0] : 8'hxx); end
    while (sb.size() > 0 && rx.size() > 0) begin
      e = sb.pop_front(); g = rx.pop_front(); total++;
      if (g !== e) begin bad++; $display("FAIL gray_byte got=%h want=%h", g, e); end
    end
    sb.delete();
  endtask

  initial begin
    rst = 1'b0; start8 = 1'b0; start10 = 1'b0;
    pixel = 8'h00; pix_valid = 1'b0; out_ready = 1'b1; sel10 = 1'b0;
    #1;
    test_reset();
    test_single_group();
    test_pattern();
    test_partial_group();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_gray();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
